// File: rtl/note_hit_pkg.sv
// Shared state encoding, bonus threshold and popcount helper for the note hit judge.
package note_hit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int unsigned COMBO_BONUS_THRESH = 16;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// One key lane: two-flop synchroniser followed by a registered rising-edge pulse.
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      sync3 <= sync2;
      pulse <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/note_hit_judge.sv
// Per-tick hit/miss judge with combo/miss tracking, score pulse pacing and game FSM.
// Define NOTE_HIT_COMBO_BONUS_EN to double the credit of each hit while combo >= 16.
module note_hit_judge
  import note_hit_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned MAX_MISSES = 8,
  parameter int unsigned COMBO_W    = 8
) (
  input  logic               INPUTCLOCK,
  input  logic               reset_n,
  input  logic               start,
  input  logic               tick,
  input  logic [LANES-1:0]   lane_note,
  input  logic [LANES-1:0]   key,
  output logic               score_inc,
  output logic [COMBO_W-1:0] combo,
  output logic [7:0]         misses,
  output logic               playing,
  output logic               game_over
);

  localparam int unsigned PEND_W = $clog2(2 * LANES + 1);
  localparam int unsigned CNT_W  = $clog2(LANES + 1);
  localparam int unsigned CSUM_W = COMBO_W + 1;

  state_e             state_q;
  state_e             state_d;
  logic [LANES-1:0]   edges;
  logic [LANES-1:0]   win_q;
  logic [LANES-1:0]   win_d;
  logic [LANES-1:0]   press_q;
  logic [LANES-1:0]   press_d;
  logic               armed_q;
  logic               armed_d;
  logic [COMBO_W-1:0] combo_q;
  logic [COMBO_W-1:0] combo_d;
  logic [7:0]         misses_q;
  logic [7:0]         misses_d;
  logic [PEND_W-1:0]  pend_q;
  logic [PEND_W-1:0]  pend_d;
  logic [PEND_W-1:0]  credit;
  logic               score_q;
  logic               score_d;
  logic               playing_q;
  logic               over_q;
  logic [CNT_W-1:0]   hits;
  logic [CNT_W-1:0]   miss_n;
  logic [CSUM_W-1:0]  combo_sum;
  logic [8:0]         miss_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    key_edge_sync u_sync (
      .clk   (INPUTCLOCK),
      .rst   (reset_n),
      .key   (key[i]),
      .pulse (edges[i])
    );
  end

  // Window scoring: a lane differing between note and press is either unplayed or a wrong press.
  always_comb begin
    hits      = CNT_W'(popcount(32'(win_q & press_q)));
    miss_n    = CNT_W'(popcount(32'(win_q ^ press_q)));
    combo_sum = {1'b0, combo_q} + CSUM_W'(hits);
    miss_sum  = 9'(misses_q) + 9'(miss_n);
`ifdef NOTE_HIT_COMBO_BONUS_EN
    credit    = (32'(combo_q) >= COMBO_BONUS_THRESH) ? (PEND_W'(hits) << 1) : PEND_W'(hits);
`else
    credit    = PEND_W'(hits);
`endif
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    press_d  = press_q;
    armed_d  = armed_q;
    combo_d  = combo_q;
    misses_d = misses_q;
    pend_d   = pend_q;
    score_d  = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        pend_d = '0;
        if (start) begin
          state_d  = PLAY;
          win_d    = '0;
          press_d  = '0;
          armed_d  = 1'b0;
          combo_d  = '0;
          misses_d = '0;
        end
      end

      PLAY: begin
        press_d = press_q | edges;
        // Pulses are spaced by a low cycle so the scoreboard sees distinct clock edges.
        if ((pend_q != '0) && !score_q) begin
          score_d = 1'b1;
          pend_d  = pend_q - PEND_W'(1);
        end
        if (tick) begin
          win_d   = lane_note;
          press_d = edges;
          armed_d = 1'b1;
          if (armed_q) begin
            if (miss_n != '0) begin
              combo_d = '0;
            end else begin
              combo_d = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
              pend_d  = pend_d + credit;
            end
            if (miss_sum >= 9'(MAX_MISSES)) begin
              misses_d = 8'(MAX_MISSES);
              state_d  = OVER;
              pend_d   = '0;
              score_d  = 1'b0;
            end else begin
              misses_d = miss_sum[7:0];
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge INPUTCLOCK) begin
    if (reset_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      press_q   <= '0;
      armed_q   <= 1'b0;
      combo_q   <= '0;
      misses_q  <= '0;
      pend_q    <= '0;
      score_q   <= 1'b0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      press_q   <= press_d;
      armed_q   <= armed_d;
      combo_q   <= combo_d;
      misses_q  <= misses_d;
      pend_q    <= pend_d;
      score_q   <= score_d;
      playing_q <= (state_d == PLAY);
      over_q    <= (state_d == OVER);
    end
  end

  assign score_inc = score_q;
  assign combo     = combo_q;
  assign misses    = misses_q;
  assign playing   = playing_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_note_hit_judge.sv
// Scoreboard bench for note_hit_judge: per-tick expectations from a lane-rule model, checked by a monitor.
module tb_note_hit_judge;

  localparam int LANES      = 4;
  localparam int MAX_MISSES = 8;
  localparam int COMBO_MAX  = 255;
  localparam int WIN        = 15;

  typedef struct {
    int pulses;
    int combo;
    int misses;
    int playing;
    int over;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       tick;
  logic [3:0] lane_note;
  logic [3:0] key;
  logic       score_inc;
  logic [7:0] combo;
  logic [7:0] misses;
  logic       playing;
  logic       game_over;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   done     = 1'b0;
  bit   abort_next = 1'b0;

  // Reference model state: 0 idle, 1 play, 2 over.
  int         m_state;
  int         m_combo;
  int         m_misses;
  bit         m_armed;
  logic [3:0] m_win;
  logic [3:0] m_press;

  note_hit_judge #(
    .LANES      (LANES),
    .MAX_MISSES (MAX_MISSES),
    .COMBO_W    (8)
  ) dut (
    .INPUTCLOCK (clk),
    .reset_n    (reset_n),
    .start      (start),
    .tick       (tick),
    .lane_note  (lane_note),
    .key        (key),
    .score_inc  (score_inc),
    .combo      (combo),
    .misses     (misses),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_combo  = 0;
    m_misses = 0;
    m_armed  = 1'b0;
    m_win    = '0;
    m_press  = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_score_inc"}, int'(score_inc), 0);
    check({tag, "_combo"}, int'(combo), 0);
    check({tag, "_misses"}, int'(misses), 0);
    check({tag, "_playing"}, int'(playing), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    if (m_state != 1) begin
      m_state  = 1;
      m_combo  = 0;
      m_misses = 0;
      m_armed  = 1'b0;
      m_win    = '0;
      m_press  = '0;
    end
    @(negedge clk);
    check("start_playing", int'(playing), 1);
    check("start_game_over", int'(game_over), 0);
    check("start_combo", int'(combo), m_combo);
    check("start_misses", int'(misses), m_misses);
    step();
  endtask

  // Model a tick: close the window by lane rules, then queue what the DUT must show.
  task automatic issue_tick(input logic [3:0] note);
    exp_t e;
    int   hits;
    int   miss;
    int   credit;
    hits   = 0;
    miss   = 0;
    credit = 0;
    if (m_state == 1) begin
      if (m_armed) begin
        for (int i = 0; i < LANES; i++) begin
          if (m_win[i] && m_press[i]) hits++;
          else if (m_win[i] && !m_press[i]) miss++;
          else if (!m_win[i] && m_press[i]) miss++;
        end
        if (miss == 0) begin
          credit = hits;
`ifdef NOTE_HIT_COMBO_BONUS_EN
          if (m_combo >= 16) credit = 2 * hits;
`endif
          m_combo = (m_combo + hits > COMBO_MAX) ? COMBO_MAX : m_combo + hits;
        end else begin
          m_combo = 0;
        end
        m_misses = (m_misses + miss >= MAX_MISSES) ? MAX_MISSES : m_misses + miss;
        if (m_misses == MAX_MISSES) begin
          m_state = 2;
          credit  = 0;
        end
      end
      m_win   = note;
      m_press = '0;
      m_armed = 1'b1;
    end
    e.pulses  = abort_next ? 0 : credit;
    e.combo   = m_combo;
    e.misses  = m_misses;
    e.playing = (m_state == 1) ? 1 : 0;
    e.over    = (m_state == 2) ? 1 : 0;
    exp_q.push_back(e);
    lane_note = note;
    tick      = 1'b1;
    step();
    tick      = 1'b0;
    lane_note = '0;
  endtask

  task automatic window(input logic [3:0] press, input logic [3:0] next_note);
    for (int c = 0; c < WIN; c++) begin
      key = (c >= 3 && c < 7) ? press : 4'b0000;
      step();
    end
    key = 4'b0000;
    if (m_state == 1) m_press = m_press | press;
    issue_tick(next_note);
  endtask

  // Monitor: each tick opens an expectation; the next tick, reset or end of run closes it.
  initial begin
    exp_t cur;
    bit   open;
    bit   chk_status;
    int   cnt;
    open       = 1'b0;
    chk_status = 1'b0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      if (chk_status) begin
        check("tick_combo", int'(combo), cur.combo);
        check("tick_misses", int'(misses), cur.misses);
        check("tick_playing", int'(playing), cur.playing);
        check("tick_game_over", int'(game_over), cur.over);
        chk_status = 1'b0;
      end
      if (score_inc) begin
        if (open) cnt++;
        else check("stray_score_inc", 1, 0);
      end
      if (open && (tick || reset_n || done)) begin
        check("tick_pulses", cnt, cur.pulses);
        open = 1'b0;
      end
      if (tick && !reset_n) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_underflow", 1, 0);
        end else begin
          cur        = exp_q.pop_front();
          open       = 1'b1;
          chk_status = 1'b1;
          cnt        = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b1;
    start     = 1'b0;
    tick      = 1'b0;
    lane_note = '0;
    key       = '0;
    model_reset();
    repeat (3) step();
    reset_n = 1'b0;
    @(negedge clk);
    check_zero("reset");
    step();

    // Single-note hit, then a missed note plus a wrong press.
    do_start();
    window(4'b0000, 4'b0001);
    window(4'b0001, 4'b0011);
    window(4'b0101, 4'b1111);

    // Full chords back to back, then a single note at high combo.
    for (int k = 0; k < 5; k++) window(4'b1111, (k == 4) ? 4'b0001 : 4'b1111);
    window(4'b0001, 4'b0000);

    // Unplayed chords until the game ends; later activity must be ignored.
    window(4'b0000, 4'b1111);
    for (int k = 0; k < 10 && m_state == 1; k++) window(4'b0000, 4'b1111);
    window(4'b1111, 4'b1111);
    window(4'b0101, 4'b0011);
    do_start();
    do_start();

    // Randomized windows with occasional restarts.
    for (int k = 0; k < 40; k++) begin
      if (m_state == 2 && $urandom_range(0, 1) == 0) do_start();
      else if ($urandom_range(0, 7) == 0) do_start();
      window(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset while three pulses are pending.
    repeat (20) step();
    reset_n = 1'b1;
    step();
    reset_n = 1'b0;
    model_reset();
    do_start();
    window(4'b0000, 4'b0111);
    abort_next = 1'b1;
    window(4'b0111, 4'b0000);
    abort_next = 1'b0;
    reset_n = 1'b1;
    step();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("midreset");
    step();

    do_start();
    window(4'b0000, 4'b0010);
    window(4'b0010, 4'b0000);

    repeat (20) step();
    done = 1'b1;
    repeat (2) @(negedge clk);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
